// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: widths, ALU op codes and
// the bubble control word loaded into ID/EX on a flush or reset.
package mips_pkg;

   localparam int DW = 32;
   localparam int CW = 5;
   localparam int RW = 5;

   localparam logic [CW-1:0] ALU_AND = 5'b00000;
   localparam logic [CW-1:0] ALU_OR  = 5'b00001;
   localparam logic [CW-1:0] ALU_ADD = 5'b00010;
   localparam logic [CW-1:0] ALU_SUB = 5'b00110;
   localparam logic [CW-1:0] ALU_SLT = 5'b00111;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
   } wb_ctrl_t;

   // A bubble must never write the register file or touch memory.
   localparam wb_ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};
   localparam logic [CW-1:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight result that targets
// the given register index, falling back to the register-file value.
module fwd_mux #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] reg_val,
   input  logic          exm_we,
   input  logic [RW-1:0] exm_idx,
   input  logic [DW-1:0] exm_res,
   input  logic          mwb_we,
   input  logic [RW-1:0] mwb_idx,
   input  logic [DW-1:0] mwb_res,
   output logic [DW-1:0] fwd_val
);

   logic exm_hit;
   logic mwb_hit;

   // Register 0 is hard-wired to zero, so a write to it is never a real producer.
   assign exm_hit = exm_we && (exm_idx != '0) && (exm_idx == idx);
   assign mwb_hit = mwb_we && (mwb_idx != '0) && (mwb_idx == idx);

   // NOTE: default assignment first so every path drives fwd_val and no latch is inferred.
   always_comb begin
      fwd_val = reg_val;
      if (exm_hit) begin
         fwd_val = exm_res;
      end else if (mwb_hit) begin
         fwd_val = mwb_res;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with rs/rt forwarding and ALUSrc selection feeding
// the EX-stage ALU; also carries store data and write-back controls onward.
module ex_operand_stage #(
   parameter int DW = mips_pkg::DW,
   parameter int CW = mips_pkg::CW
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Stall,
   input  logic          Flush,
   input  logic [CW-1:0] ID_ALUControl,
   input  logic [DW-1:0] ID_ReadData1,
   input  logic [DW-1:0] ID_ReadData2,
   input  logic [DW-1:0] ID_Imm,
   input  logic [4:0]    ID_Rs,
   input  logic [4:0]    ID_Rt,
   input  logic [4:0]    ID_WriteReg,
   input  logic          ID_ALUSrc,
   input  logic          ID_RegWrite,
   input  logic          ID_MemRead,
   input  logic          ID_MemWrite,
   input  logic          EXM_RegWrite,
   input  logic [4:0]    EXM_WriteReg,
   input  logic [DW-1:0] EXM_Result,
   input  logic          MWB_RegWrite,
   input  logic [4:0]    MWB_WriteReg,
   input  logic [DW-1:0] MWB_Result,
   output logic [CW-1:0] ALUControl,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [DW-1:0] StoreData,
   output logic [4:0]    WriteReg,
   output logic          RegWrite,
   output logic          MemRead,
   output logic          MemWrite
);

   import mips_pkg::*;

   logic [CW-1:0] alu_q;
   logic [DW-1:0] rd1_q;
   logic [DW-1:0] rd2_q;
   logic [DW-1:0] imm_q;
   logic [RW-1:0] rs_q;
   logic [RW-1:0] rt_q;
   logic [RW-1:0] wr_q;
   logic          src_q;
   wb_ctrl_t      ctrl_q;

   logic [DW-1:0] rs_fwd;
   logic [DW-1:0] rt_fwd;

   // Flush beats Stall: a squashed instruction must leave even if ID is held.
   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         alu_q  <= CW'(ALU_BUBBLE);
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         wr_q   <= '0;
         src_q  <= 1'b0;
         ctrl_q <= CTRL_BUBBLE;
      end else if (Flush) begin
         alu_q  <= CW'(ALU_BUBBLE);
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         wr_q   <= '0;
         src_q  <= 1'b0;
         ctrl_q <= CTRL_BUBBLE;
      end else if (!Stall) begin
         alu_q  <= ID_ALUControl;
         rd1_q  <= ID_ReadData1;
         rd2_q  <= ID_ReadData2;
         imm_q  <= ID_Imm;
         rs_q   <= ID_Rs;
         rt_q   <= ID_Rt;
         wr_q   <= ID_WriteReg;
         src_q  <= ID_ALUSrc;
         ctrl_q <= '{reg_write: ID_RegWrite, mem_read: ID_MemRead, mem_write: ID_MemWrite};
      end
   end

   // Forwarding stays combinational so a stalled instruction keeps tracking newer results.
   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .idx     (rs_q),
      .reg_val (rd1_q),
      .exm_we  (EXM_RegWrite),
      .exm_idx (EXM_WriteReg),
      .exm_res (EXM_Result),
      .mwb_we  (MWB_RegWrite),
      .mwb_idx (MWB_WriteReg),
      .mwb_res (MWB_Result),
      .fwd_val (rs_fwd)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .idx     (rt_q),
      .reg_val (rd2_q),
      .exm_we  (EXM_RegWrite),
      .exm_idx (EXM_WriteReg),
      .exm_res (EXM_Result),
      .mwb_we  (MWB_RegWrite),
      .mwb_idx (MWB_WriteReg),
      .mwb_res (MWB_Result),
      .fwd_val (rt_fwd)
   );

   assign ALUControl = alu_q;
   assign A          = rs_fwd;
   assign B          = src_q ? imm_q : rt_fwd;
   assign StoreData  = rt_fwd;
   assign WriteReg   = wr_q;
   assign RegWrite   = ctrl_q.reg_write;
   assign MemRead    = ctrl_q.mem_read;
   assign MemWrite   = ctrl_q.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios followed by a
// randomized run against a shadow ID/EX model with independent forwarding.
module tb_ex_operand_stage;

   import mips_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst, Stall, Flush;
   logic [4:0]  ID_ALUControl;
   logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
   logic [4:0]  ID_Rs, ID_Rt, ID_WriteReg;
   logic        ID_ALUSrc, ID_RegWrite, ID_MemRead, ID_MemWrite;
   logic        EXM_RegWrite, MWB_RegWrite;
   logic [4:0]  EXM_WriteReg, MWB_WriteReg;
   logic [31:0] EXM_Result, MWB_Result;
   logic [4:0]  ALUControl, WriteReg;
   logic [31:0] A, B, StoreData;
   logic        RegWrite, MemRead, MemWrite;

   ex_operand_stage #(.DW(32), .CW(5)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
      .ID_ALUControl(ID_ALUControl), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
      .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_WriteReg(ID_WriteReg),
      .ID_ALUSrc(ID_ALUSrc), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
      .ID_MemWrite(ID_MemWrite),
      .EXM_RegWrite(EXM_RegWrite), .EXM_WriteReg(EXM_WriteReg), .EXM_Result(EXM_Result),
      .MWB_RegWrite(MWB_RegWrite), .MWB_WriteReg(MWB_WriteReg), .MWB_Result(MWB_Result),
      .ALUControl(ALUControl), .A(A), .B(B), .StoreData(StoreData),
      .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0]  alu;
      logic [31:0] a, b, sd;
      logic [4:0]  wr;
      logic        rw, mr, mw;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] alu, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic mw);
      exp_t e;
      e.alu = alu; e.a = a; e.b = b; e.sd = sd; e.wr = wr; e.rw = rw; e.mr = mr; e.mw = mw;
      sb.push_back(e);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      check({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, ".ALUControl"}, 32'(ALUControl), 32'(e.alu));
         check({tag, ".A"},          A,               e.a);
         check({tag, ".B"},          B,               e.b);
         check({tag, ".StoreData"},  StoreData,       e.sd);
         check({tag, ".WriteReg"},   32'(WriteReg),   32'(e.wr));
         check({tag, ".ctrl"},       {29'd0, RegWrite, MemRead, MemWrite}, {29'd0, e.rw, e.mr, e.mw});
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_id(input logic [4:0] alu, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] wr, input logic src,
                           input logic rw, input logic mr, input logic mw);
      ID_ALUControl = alu; ID_ReadData1 = rd1; ID_ReadData2 = rd2; ID_Imm = imm;
      ID_Rs = rs; ID_Rt = rt; ID_WriteReg = wr; ID_ALUSrc = src;
      ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw;
   endtask

   task automatic drive_fwd(input logic ew, input logic [4:0] ei, input logic [31:0] er,
                            input logic mw, input logic [4:0] mi, input logic [31:0] mr);
      EXM_RegWrite = ew; EXM_WriteReg = ei; EXM_Result = er;
      MWB_RegWrite = mw; MWB_WriteReg = mi; MWB_Result = mr;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
      if (EXM_RegWrite && EXM_WriteReg != 5'd0 && EXM_WriteReg == idx) return EXM_Result;
      if (MWB_RegWrite && MWB_WriteReg != 5'd0 && MWB_WriteReg == idx) return MWB_Result;
      return v;
   endfunction

   // Shadow ID/EX state for the randomized phase.
   logic [4:0]  s_alu, s_rs, s_rt, s_wr;
   logic [31:0] s_rd1, s_rd2, s_imm;
   logic        s_src, s_rw, s_mr, s_mw;

   initial begin
      Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
      drive_id(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_fwd(0, 0, 0, 0, 0, 0);
      step(); step();
      Rst = 1'b0;

      // Load something non-zero, then reset asynchronously mid-cycle.
      drive_id(ALU_SUB, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd4, 0, 1, 1, 1);
      step();
      push(ALU_SUB, 32'h11, 32'h22, 32'h22, 5'd4, 1, 1, 1);
      compare("load");
      drive_fwd(1, 5'd1, 32'hDEAD, 0, 0, 0);
      #1 Rst = 1'b1;
      #1;
      push(ALU_ADD, 0, 0, 0, 5'd0, 0, 0, 0);
      compare("reset_async");
      #1 Rst = 1'b0;
      step();
      push(ALU_SUB, 32'hDEAD, 32'h22, 32'h22, 5'd4, 1, 1, 1);
      compare("post_reset");
      drive_fwd(0, 0, 0, 0, 0, 0);

      // Plain pass-through.
      drive_id(ALU_ADD, 32'd15, 32'd10, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
      step();
      push(ALU_ADD, 32'd15, 32'd10, 32'd10, 5'd3, 1, 0, 0);
      compare("pass");

      // Immediate on B, store data still the rt value.
      drive_id(ALU_ADD, 32'd1, 32'd7, 32'hFFFF_FFFB, 5'd1, 5'd2, 5'd0, 1, 0, 0, 1);
      step();
      push(ALU_ADD, 32'd1, 32'hFFFF_FFFB, 32'd7, 5'd0, 0, 0, 1);
      compare("alusrc");

      // Forwarding priority on rs = 3.
      drive_id(ALU_SLT, 32'h100, 32'h200, 32'h0, 5'd3, 5'd5, 5'd6, 0, 1, 0, 0);
      drive_fwd(1, 5'd3, 32'd5, 1, 5'd3, 32'd9);
      step();
      push(ALU_SLT, 32'd5, 32'h200, 32'h200, 5'd6, 1, 0, 0);
      compare("fwd_exm_wins");
      EXM_RegWrite = 1'b0;
      #1;
      push(ALU_SLT, 32'd9, 32'h200, 32'h200, 5'd6, 1, 0, 0);
      compare("fwd_mwb");
      drive_id(ALU_ADD, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      drive_fwd(1, 5'd0, 32'd5, 1, 5'd0, 32'd9);
      step();
      push(ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0);
      compare("fwd_reg0");

      // Stall holds the instruction while forwarding keeps tracking.
      drive_id(ALU_OR, 32'hAAA, 32'hBBB, 32'h0, 5'd3, 5'd4, 5'd7, 0, 1, 0, 0);
      drive_fwd(1, 5'd3, 32'd5, 0, 5'd4, 32'h44);
      step();
      push(ALU_OR, 32'd5, 32'hBBB, 32'hBBB, 5'd7, 1, 0, 0);
      compare("stall_pre");
      Stall = 1'b1;
      drive_id(ALU_AND, 32'd1, 32'd2, 32'd3, 5'd9, 5'd10, 5'd8, 1, 0, 1, 1);
      step();
      push(ALU_OR, 32'd5, 32'hBBB, 32'hBBB, 5'd7, 1, 0, 0);
      compare("stall_1");
      EXM_Result = 32'd6; MWB_RegWrite = 1'b1;
      step();
      push(ALU_OR, 32'd6, 32'h44, 32'h44, 5'd7, 1, 0, 0);
      compare("stall_2");

      // Flush wins over Stall.
      Flush = 1'b1;
      drive_id(ALU_SUB, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd9, 0, 1, 0, 1);
      drive_fwd(1, 5'd0, 32'hBAD, 0, 0, 0);
      step();
      push(ALU_ADD, 0, 0, 0, 5'd0, 0, 0, 0);
      compare("flush_stall");
      Flush = 1'b0; Stall = 1'b0;

      // Randomized run against the shadow model.
      s_alu = ALU_ADD; s_rd1 = 0; s_rd2 = 0; s_imm = 0; s_rs = 0; s_rt = 0; s_wr = 0;
      s_src = 0; s_rw = 0; s_mr = 0; s_mw = 0;
      for (int i = 0; i < 60; i++) begin
         drive_id(5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         Stall = ($urandom_range(0, 3) == 0);
         Flush = ($urandom_range(0, 7) == 0);
         if (Flush) begin
            s_alu = ALU_ADD; s_rd1 = 0; s_rd2 = 0; s_imm = 0; s_rs = 0; s_rt = 0; s_wr = 0;
            s_src = 0; s_rw = 0; s_mr = 0; s_mw = 0;
         end else if (!Stall) begin
            s_alu = ID_ALUControl; s_rd1 = ID_ReadData1; s_rd2 = ID_ReadData2; s_imm = ID_Imm;
            s_rs = ID_Rs; s_rt = ID_Rt; s_wr = ID_WriteReg; s_src = ID_ALUSrc;
            s_rw = ID_RegWrite; s_mr = ID_MemRead; s_mw = ID_MemWrite;
         end
         step();
         drive_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
         #1;
         push(s_alu, fwd(s_rs, s_rd1), s_src ? s_imm : fwd(s_rt, s_rd2), fwd(s_rt, s_rd2),
              s_wr, s_rw, s_mr, s_mw);
         compare($sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and ALUSrc selection, directly upstream of the ALU32Bit EX-stage ALU.
- Captures the decoded instruction from ID, resolves RAW hazards against the EX/MEM and MEM/WB results, and drives the ALU's ALUControl, A and B.
- Also passes the store data and write-back controls down to EX/MEM.

Parameters:
- DW, 32, datapath width
- CW, 5, ALU control width; ALU op codes are ADD 00010, SUB 00110, AND 00000, OR 00001, SLT 00111

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous active-high reset
- Stall  in  1  hold all ID/EX registers
- Flush  in  1  load a bubble instead of the ID inputs
- ID_ALUControl  in  CW  decoded ALU op
- ID_ReadData1  in  DW  rs value from the register file
- ID_ReadData2  in  DW  rt value from the register file
- ID_Imm  in  DW  sign-extended immediate
- ID_Rs  in  5  rs index
- ID_Rt  in  5  rt index
- ID_WriteReg  in  5  destination index (RegDst already resolved)
- ID_ALUSrc  in  1  1 selects the immediate for B
- ID_RegWrite  in  1  write-back enable
- ID_MemRead  in  1  load control
- ID_MemWrite  in  1  store control
- EXM_RegWrite  in  1  EX/MEM write enable
- EXM_WriteReg  in  5  EX/MEM destination index
- EXM_Result  in  DW  EX/MEM ALU result
- MWB_RegWrite  in  1  MEM/WB write enable
- MWB_WriteReg  in  5  MEM/WB destination index
- MWB_Result  in  DW  MEM/WB write-back data
- ALUControl  out  CW  to the ALU
- A  out  DW  to the ALU
- B  out  DW  to the ALU
- StoreData  out  DW  forwarded rt value, to EX/MEM
- WriteReg  out  5  registered destination index
- RegWrite  out  1  registered write-back enable
- MemRead  out  1  registered load control
- MemWrite  out  1  registered store control

Behaviour:
- Clock and reset: single clock Clk. Rst is asynchronous and active-high. All state updates on the rising edge of Clk.
- Reset: all ID/EX registers clear to zero, except ALUControl = ADD (00010).
  - Outputs after reset: A = 0, B = 0, StoreData = 0, RegWrite = MemRead = MemWrite = 0, WriteReg = 0.
  - Forwarding inputs still act combinationally while Rst is asserted. Registered rs/rt are 0 during reset, so no forwarding occurs.
- Register update priority per edge: Flush > Stall > load.
  - Flush: bubble. ALUControl = ADD; RegWrite, MemRead, MemWrite = 0; all index and data fields = 0.
  - Stall (without Flush): hold every register.
  - Otherwise: capture all ID_* inputs.
- Latency: 1 cycle from ID inputs to registered fields. A, B and StoreData are combinational from the registered fields plus the forwarding inputs, within the same cycle.
- Forwarding, evaluated independently for rs and rt:
  - If EXM_RegWrite and EXM_WriteReg != 0 and EXM_WriteReg == index: use EXM_Result.
  - Else if MWB_RegWrite and MWB_WriteReg != 0 and MWB_WriteReg == index: use MWB_Result.
  - Else: use the registered register-file value.
  - EX/MEM always wins when both stages match.
  - Register 0 is never forwarded.
- Output selection:
  - A = forwarded rs.
  - StoreData = forwarded rt.
  - B = registered Imm when ALUSrc = 1, else forwarded rt.
- Held instruction under Stall: forwarding is re-evaluated every cycle against the current EX/MEM and MEM/WB inputs.
- Load-use hazards are out of scope. The hazard unit raises Stall or Flush upstream; this block does not detect them.
- Arithmetic: none. Pure selection; all data paths are full DW bits with no truncation.

Decomposition:
- Shared package (mips_pkg):
  - ALU op code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - DW, CW, and the register index width 5.
  - Bubble control constant.
- One sub-module: fwd_mux.
  - Inputs: index, registered value, the two stage write enables, indices and results.
  - Output: forwarded value.
  - Instantiated twice, for rs and rt.

Test Plan:
- Reset: assert Rst mid-cycle with non-zero ID inputs held → outputs go immediately to ALUControl = 00010, A = B = 0, all controls 0; after release, the first edge captures ID_ALUControl = 00110.
- Plain pass-through: ID_ReadData1 = 15, ID_ReadData2 = 10, ALUSrc = 0, ALUControl = 00010, no forwarding matches → next cycle A = 15, B = 10, StoreData = 10.
- ALUSrc: ID_ALUSrc = 1, ID_Imm = 0xFFFFFFFB, ID_ReadData2 = 7 → B = 0xFFFFFFFB, StoreData = 7.
- Forwarding priority, with registered Rs = 3:
  - EXM and MWB both writing reg 3, EXM_Result = 5, MWB_Result = 9 → A = 5.
  - Drop EXM_RegWrite → A = 9.
  - Set EXM_WriteReg = MWB_WriteReg = 0 with RegWrite high, Rs = 0, ReadData1 = 0 → A = 0.
- Stall with changing forwarding: Stall = 1 for 2 cycles with new ID inputs → registered fields unchanged; change EXM_Result from 5 to 6 while matching → A follows 5 then 6.
- Flush vs Stall: Flush = Stall = 1 with ID_RegWrite = 1 → next cycle RegWrite = 0, MemWrite = 0, ALUControl = 00010, WriteReg = 0.
